// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader that writes 32-bit words to memory and holds the CPU in reset until done
//
// Optional feature macro: LOADER_VERIFY_EN (adds read-back READ/CHECK after every write)
//
// Ports:
//   clk                    clock, rising edge
//   reset                  asynchronous active-low reset
//   in_byte/in_valid       byte stream from host link
//   in_ready               loader accepts a byte this cycle
//   addr                   memory byte address (0 when no strobe)
//   data_mem_in            big-endian write word (0 when not writing)
//   w_data_size            2'b11 during a write, else 2'b00
//   data_mem_write_enable  write strobe
//   data_mem_read_enable   read strobe
//   data_mem_out           registered read data, valid the cycle after the read strobe
//   cpu_reset              active-high CPU reset, released when the load completes
//   done / error           sticky completion / failure flags
//   err_addr               failing word address, or BASE_ADDR for an oversize image
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          MEM_BYTES = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] addr,
    output logic [31:0] data_mem_in,
    output logic [1:0]  w_data_size,
    output logic        data_mem_write_enable,
    output logic        data_mem_read_enable,
    input  logic [31:0] data_mem_out,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [31:0] err_addr
);
`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {HDR0, HDR1, COLLECT, WRITE, READ, CHECK, DONE, ERROR} state_t;
`else
    typedef enum logic [2:0] {HDR0, HDR1, COLLECT, WRITE, DONE, ERROR} state_t;
`endif
    state_t      state, nxt;
    logic [15:0] n, i, hdr_n;
    logic [1:0]  cnt;
    logic [31:0] word, cur_addr;
    logic        live, take, last, oversize, adv;

    // live keeps in_ready low while reset is held and until the first edge after release
    assign in_ready = live && (state == HDR0 || state == HDR1 || state == COLLECT);
    assign take     = in_valid && in_ready;
    assign hdr_n    = {n[7:0], in_byte};
    assign oversize = {14'd0, hdr_n, 2'b00} > 32'(MEM_BYTES);
    assign cur_addr = BASE_ADDR + {14'd0, i, 2'b00};
    assign last     = (i + 16'd1) == n;

`ifdef LOADER_VERIFY_EN
    assign adv                  = state == CHECK && data_mem_out == word;
    assign data_mem_read_enable = state == READ;
`else
    logic unused_mem;
    assign unused_mem           = ^data_mem_out;
    assign adv                  = state == WRITE;
    assign data_mem_read_enable = 1'b0;
`endif
    assign data_mem_write_enable = state == WRITE;
    assign w_data_size = data_mem_write_enable ? 2'b11 : 2'b00;
    assign addr        = (data_mem_write_enable || data_mem_read_enable) ? cur_addr : 32'd0;
    assign data_mem_in = data_mem_write_enable ? word : 32'd0;
    assign cpu_reset   = state != DONE;
    assign done        = state == DONE;
    assign error       = state == ERROR;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= HDR0;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            HDR0:    nxt = take ? HDR1 : HDR0;
            HDR1:    nxt = !take ? HDR1 : hdr_n == 16'd0 ? DONE : oversize ? ERROR : COLLECT;
            COLLECT: nxt = (take && cnt == 2'd3) ? WRITE : COLLECT;
`ifdef LOADER_VERIFY_EN
            WRITE:   nxt = READ;
            READ:    nxt = CHECK;
            CHECK:   nxt = !adv ? ERROR : last ? DONE : COLLECT;
`else
            WRITE:   nxt = last ? DONE : COLLECT;
`endif
            default: nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live     <= 1'b0;
            n        <= 16'd0;
            i        <= 16'd0;
            cnt      <= 2'd0;
            word     <= 32'd0;
            err_addr <= 32'd0;
        end else begin
            live <= 1'b1;
            if (state == HDR0 && take) n <= {8'd0, in_byte};
            if (state == HDR1 && take) begin
                n   <= hdr_n;
                i   <= 16'd0;
                cnt <= 2'd0;
                if (hdr_n != 16'd0 && oversize) err_addr <= BASE_ADDR;
            end
            if (state == COLLECT && take) begin
                word <= {word[23:0], in_byte};
                cnt  <= cnt + 2'd1;
            end
            if (adv) i <= i + 16'd1;
`ifdef LOADER_VERIFY_EN
            if (state == CHECK && !adv) err_addr <= cur_addr;
`endif
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader with a byte-wide memory model
module tb_prog_loader;
    logic        clk = 0, reset = 0, in_valid = 0, clr = 1, stuck = 0;
    logic [7:0]  in_byte = 0;
    logic        in_ready, we, re, cpu_reset, done, error;
    logic [31:0] addr, dmi, err_addr, rdata = 0;
    logic [1:0]  wsz;
    logic [7:0]  mem [0:63];
    int          n_wr = 0, n_rd = 0, n_acc = 0, ovl = 0;
    int          errors = 0, checks = 0;

    prog_loader dut (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .addr(addr), .data_mem_in(dmi), .w_data_size(wsz), .data_mem_write_enable(we),
        .data_mem_read_enable(re), .data_mem_out(rdata), .cpu_reset(cpu_reset), .done(done),
        .error(error), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    // Big-endian byte memory with registered read; stuck forces stored bit 0 of each word low
    always @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < 64; k++) mem[k] <= 8'h00;
            n_wr <= 0; n_rd <= 0; n_acc <= 0; ovl <= 0;
        end else begin
            if (we) begin
                mem[addr[5:0]]         <= dmi[31:24];
                mem[addr[5:0] + 6'd1]  <= dmi[23:16];
                mem[addr[5:0] + 6'd2]  <= dmi[15:8];
                mem[addr[5:0] + 6'd3]  <= dmi[7:1] == 7'd0 && stuck ? 8'h00 : {dmi[7:1], dmi[0] & ~stuck};
                n_wr <= n_wr + 1;
            end
            if (re) begin
                rdata <= {mem[addr[5:0]], mem[addr[5:0] + 6'd1], mem[addr[5:0] + 6'd2], mem[addr[5:0] + 6'd3]};
                n_rd  <= n_rd + 1;
            end
            if (we && re) ovl <= ovl + 1;
            if (in_valid && in_ready) n_acc <= n_acc + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 0; in_valid = 0; stuck = 0; clr = 1;
        tick(1);
        clr = 0; reset = 1;
        tick(1);
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        in_byte = b; in_valid = 1;
        while (!in_ready && t < 50) begin tick(1); t++; end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL send_ready: byte %02h in_ready=%0b want 1", b, in_ready); end
        tick(1);
    endtask

    task automatic send_slow(input logic [7:0] b);
        send(b);
        in_valid = 0;
        tick(1);
    endtask

    task automatic wait_end();
        int t = 0;
        while (!done && !error && t < 30) begin tick(1); t++; end
        checks++;
        if (!(done || error)) begin errors++; $display("FAIL wait_end: done=%0b error=%0b want one set", done, error); end
    endtask

    task automatic test_reset();
        reset = 0; clr = 1;
        tick(2);
        checks++;
        if ({in_ready, we, re, wsz, cpu_reset, done, error} !== 8'b0000_0100 || addr !== 0 || dmi !== 0 || err_addr !== 0) begin
            errors++;
            $display("FAIL reset_vals: rdy=%0b we=%0b re=%0b wsz=%0d cpu_rst=%0b done=%0b err=%0b addr=%h dmi=%h ea=%h want 0,0,0,0,1,0,0,0,0,0",
                     in_ready, we, re, wsz, cpu_reset, done, error, addr, dmi, err_addr);
        end
        clr = 0; reset = 1;
        tick(1);
        checks++;
        if (in_ready !== 1'b1 || cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_release: in_ready=%0b cpu_reset=%0b want 1 1", in_ready, cpu_reset); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s [10] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13};
        do_reset();
        foreach (s[k]) send(s[k]);
        in_valid = 0;
        checks++;
        if (we !== 1 || re !== 0 || addr !== 32'd4 || dmi !== 32'h00000013 || wsz !== 2'b11) begin
            errors++; $display("FAIL b2b_write: we=%0b re=%0b addr=%h dmi=%h wsz=%0d want 1 0 4 00000013 3", we, re, addr, dmi, wsz);
        end
`ifdef LOADER_VERIFY_EN
        tick(1);
        checks++;
        if (re !== 1 || we !== 0 || addr !== 32'd4 || dmi !== 0 || wsz !== 0) begin
            errors++; $display("FAIL b2b_read: re=%0b we=%0b addr=%h dmi=%h wsz=%0d want 1 0 4 0 0", re, we, addr, dmi, wsz);
        end
        tick(1);
        checks++;
        if (re !== 0 || we !== 0 || addr !== 0 || done !== 0 || cpu_reset !== 1) begin
            errors++; $display("FAIL b2b_check: re=%0b we=%0b addr=%h done=%0b cpu_reset=%0b want 0 0 0 0 1", re, we, addr, done, cpu_reset);
        end
`endif
        tick(1);
        checks++;
        if (done !== 1 || cpu_reset !== 0 || error !== 0 || in_ready !== 0) begin
            errors++; $display("FAIL b2b_done: done=%0b cpu_reset=%0b error=%0b in_ready=%0b want 1 0 0 0", done, cpu_reset, error, in_ready);
        end
        checks++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'hDEADBEEF || {mem[4], mem[5], mem[6], mem[7]} !== 32'h00000013) begin
            errors++; $display("FAIL b2b_mem: got %02h%02h%02h%02h %02h%02h%02h%02h want DEADBEEF 00000013",
                               mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]);
        end
        checks++;
        if (n_wr !== 2 || n_acc !== 10 || ovl !== 0) begin
            errors++; $display("FAIL b2b_counts: writes=%0d accepts=%0d overlap=%0d want 2 10 0", n_wr, n_acc, ovl);
        end
    endtask

    task automatic test_empty();
        do_reset();
        send(8'h00); send(8'h00);
        checks++;
        if (done !== 1 || cpu_reset !== 0 || error !== 0) begin
            errors++; $display("FAIL empty_done: done=%0b cpu_reset=%0b error=%0b want 1 0 0", done, cpu_reset, error);
        end
        tick(4);
        in_valid = 0;
        checks++;
        if (n_wr !== 0 || n_rd !== 0 || n_acc !== 2 || in_ready !== 0) begin
            errors++; $display("FAIL empty_idle: writes=%0d reads=%0d accepts=%0d in_ready=%0b want 0 0 2 0", n_wr, n_rd, n_acc, in_ready);
        end
    endtask

    task automatic test_oversize();
        do_reset();
        send(8'h00); send(8'h0B);
        tick(3);
        in_valid = 0;
        checks++;
        if (error !== 1 || err_addr !== 0 || cpu_reset !== 1 || done !== 0 || in_ready !== 0 || n_acc !== 2) begin
            errors++; $display("FAIL oversize: error=%0b ea=%h cpu_reset=%0b done=%0b in_ready=%0b accepts=%0d want 1 0 1 0 0 2",
                               error, err_addr, cpu_reset, done, in_ready, n_acc);
        end
        do_reset();
        send(8'h00); send(8'h0A);
        in_valid = 0;
        checks++;
        if (error !== 0 || in_ready !== 1 || done !== 0) begin
            errors++; $display("FAIL fits_exact: error=%0b in_ready=%0b done=%0b want 0 1 0", error, in_ready, done);
        end
    endtask

    task automatic test_stuck_bit();
        do_reset();
        stuck = 1;
        send(8'h00); send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
        in_valid = 0;
`ifdef LOADER_VERIFY_EN
        tick(3);
        checks++;
        if (error !== 1 || err_addr !== 32'd0 || done !== 0 || cpu_reset !== 1) begin
            errors++; $display("FAIL stuck_err: error=%0b ea=%h done=%0b cpu_reset=%0b want 1 0 0 1", error, err_addr, done, cpu_reset);
        end
`else
        tick(1);
        checks++;
        if (error !== 0 || done !== 1 || cpu_reset !== 0) begin
            errors++; $display("FAIL stuck_noverify: error=%0b done=%0b cpu_reset=%0b want 0 1 0", error, done, cpu_reset);
        end
`endif
        checks++;
        if (mem[3] !== 8'h00 || n_wr !== 1) begin errors++; $display("FAIL stuck_mem: mem3=%02h writes=%0d want 00 1", mem[3], n_wr); end
        stuck = 0;
    endtask

    task automatic test_toggle();
        logic [7:0] s [10] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'h0F, 8'hF0};
        do_reset();
        foreach (s[k]) send_slow(s[k]);
        wait_end();
        checks++;
        if (done !== 1 || error !== 0 || n_acc !== 10 || n_wr !== 2 || ovl !== 0) begin
            errors++; $display("FAIL toggle_state: done=%0b error=%0b accepts=%0d writes=%0d overlap=%0d want 1 0 10 2 0",
                               done, error, n_acc, n_wr, ovl);
        end
        checks++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h11223344 || {mem[4], mem[5], mem[6], mem[7]} !== 32'hA55A0FF0) begin
            errors++; $display("FAIL toggle_mem: got %02h%02h%02h%02h %02h%02h%02h%02h want 11223344 A55A0FF0",
                               mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]);
        end
    endtask

    task automatic test_reset_midword();
        do_reset();
        send(8'h00); send(8'h01); send(8'hCA); send(8'hFE); send(8'hBA);
        in_valid = 0;
        reset = 0;
        #1;
        checks++;
        if ({in_ready, we, re, wsz, cpu_reset, done, error} !== 8'b0000_0100 || addr !== 0 || dmi !== 0 || err_addr !== 0) begin
            errors++; $display("FAIL midword_pulse: rdy=%0b we=%0b re=%0b wsz=%0d cpu_rst=%0b done=%0b err=%0b addr=%h dmi=%h want 0,0,0,0,1,0,0,0,0",
                               in_ready, we, re, wsz, cpu_reset, done, error, addr, dmi);
        end
        tick(1);
        reset = 1;
        tick(1);
        checks++;
        if (n_wr !== 0) begin errors++; $display("FAIL midword_nowrite: writes=%0d want 0", n_wr); end
        send(8'h00); send(8'h01); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        in_valid = 0;
        wait_end();
        checks++;
        if (done !== 1 || n_wr !== 1 || {mem[0], mem[1], mem[2], mem[3]} !== 32'h12345678) begin
            errors++; $display("FAIL midword_resend: done=%0b writes=%0d mem=%02h%02h%02h%02h want 1 1 12345678",
                               done, n_wr, mem[0], mem[1], mem[2], mem[3]);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_empty();
        test_oversize();
        test_stuck_bit();
        test_toggle();
        test_reset_midword();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader acting as the initiator on the memory port that the CPU otherwise drives: it takes a framed image from a byte source, writes it as 32-bit words into a memory model or macro, optionally reads each word back to check it, and holds the CPU in reset until the image is in place. It sits between a host byte link (a testbench stream or a future UART receiver), the shared instruction/data memory port and the `cpu` reset input.

## Interface
Parameters:
- `BASE_ADDR`, 0: byte address of the first loaded word.
- `MEM_BYTES`, 40: memory capacity in bytes; images larger than this are rejected.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_byte`  in  8  stream byte.
- `in_valid`  in  1  `in_byte` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `addr`  out  32  memory byte address.
- `data_mem_in`  out  32  write data, big-endian: [31:24] goes to `addr`, [7:0] to `addr+3`.
- `w_data_size`  out  2  write size; always 'b11 (word) while a write is active, 'b00 otherwise.
- `data_mem_write_enable`  out  1  write strobe.
- `data_mem_read_enable`  out  1  read strobe.
- `data_mem_out`  in  32  read data, registered by memory; valid the cycle after the read strobe.
- `cpu_reset`  out  1  active-high reset to `cpu`; 1 until load completes.
- `done`  out  1  sticky, image loaded successfully.
- `error`  out  1  sticky, load failed.
- `err_addr`  out  32  address of the failing word, or `BASE_ADDR` for an oversize image.

## Operation
- Frame format: 2 header bytes giving word count N (big-endian, 16 bits), then N×4 payload bytes, MSB first per word.
- FSM states: HDR0, HDR1, COLLECT, WRITE, READ, CHECK, DONE, ERROR.
- HDR0 / HDR1: accept N[15:8], then N[7:0].
  - After HDR1: if N==0, go to DONE.
  - If N×4 > MEM_BYTES, go to ERROR with `err_addr`=`BASE_ADDR`.
  - Otherwise go to COLLECT with word index i=0.
- COLLECT: shift 4 accepted bytes into the word register, then go to WRITE.
- WRITE (1 cycle):
  - Drives `data_mem_write_enable`=1, `w_data_size`='b11, `addr`=BASE_ADDR+4i (32-bit, modulo 2^32) and `data_mem_in`=word.
  - Next state is READ with verify enabled, otherwise the advance step.
- READ (1 cycle): `data_mem_read_enable`=1, same `addr`. Then CHECK.
- CHECK: compare `data_mem_out` with the word register.
  - Mismatch: go to ERROR and latch `err_addr`=BASE_ADDR+4i.
  - Match: advance.
- Advance: i←i+1; if i==N go to DONE, else go to COLLECT.
- DONE: `done`=1, `cpu_reset`=0. Holds until reset; all further stream bytes are refused.
- ERROR: `error`=1, `cpu_reset` stays 1. Holds until reset.
- `in_ready`=1 only in HDR0, HDR1 and COLLECT. A byte transfers on a rising edge with `in_valid`&&`in_ready`.
- Both strobes are never high in the same cycle. `addr` and `data_mem_in` are 0 whenever no strobe is active.

## Timing
- Reset (asynchronous, any state, mid-word or mid-check) gives:
  - state HDR0, i=0, word register 0;
  - `cpu_reset`=1, `done`=0, `error`=0, `err_addr`=0;
  - strobes 0, `w_data_size`=0, `addr`=0, `data_mem_in`=0;
  - `in_ready`=0 while reset is asserted, 1 from the first cycle after release.
- A partial frame is discarded on reset, and the stream restarts at a header.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid` to `in_ready`.
- Per word with verify, from the 4th byte accepted: WRITE in cycle +1, READ in +2, CHECK in +3. `in_ready` returns in +4 (or DONE is entered in +4).
- Per word without verify: WRITE in +1; COLLECT or DONE in +2.
- `in_valid` may stay high continuously; back-pressure is the only flow control.
- `done` and `cpu_reset` change in the same edge, so the CPU leaves reset exactly one cycle after the last write (or check).

## Configuration
- `LOADER_VERIFY_EN` defined: READ and CHECK states are present and mismatches raise `error`.
- Not defined: READ and CHECK are removed, `data_mem_read_enable` is tied 0, `data_mem_out` is ignored, and `error` only ever reports an oversize image.

## Test plan
- Stream 00 02 DE AD BE EF 00 00 00 13 with verify and a correct memory model -> words DEADBEEF written at addr 0 and 00000013 at addr 4. Memory bytes 0..3 read DE AD BE EF. `done`=1 and `cpu_reset`=0 one cycle after the second CHECK; `error`=0.
- Header 00 00 -> DONE immediately after HDR1; no strobes ever asserted.
- Header 00 0B with MEM_BYTES=40 -> ERROR after HDR1, `err_addr`=0, `cpu_reset` stays 1, `in_ready`=0 afterwards.
- Memory model forcing bit 0 stuck low, stream 00 01 00 00 00 01 with verify -> ERROR, `err_addr`=BASE_ADDR, `done`=0.
- `in_valid` toggling every other cycle during a 2-word frame -> identical memory contents. No byte is lost or duplicated, and a byte is accepted only when `in_ready`=1.
- `reset` pulsed low after 3 payload bytes, then the full frame resent -> no write from the aborted word, all outputs at reset values during the pulse, and the final memory matches the resent frame.
